vram_port_arbiter: RTL

Single-port VRAM access arbiter for the VGA text-mode display. It sits between the Avalon-MM slave path, the character-fetch requester in the pixel pipeline and the single-port 600×32 VRAM, which has one cycle of read latency. Each cycle it grants at most one RAM access. Video fetches win by default; a starvation counter bounds how long Avalon can wait. Avalon accesses complete through waitrequest.

---
 rtl/vram_arb_pkg.sv | 6 +
 rtl/vram_arb_starve_ctr.sv | 16 +
 rtl/vram_port_arbiter.sv | 77 +++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared constants and types for the VRAM port arbiter
package vram_arb_pkg;
    localparam int VRAM_WORDS = 600;
    typedef enum logic {IDLE, RD_RET} arb_state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_AVL} gnt_t;
endpackage

// File: rtl/vram_arb_starve_ctr.sv
// vram_arb_starve_ctr: saturating count of cycles a pending Avalon access went ungranted
module vram_arb_starve_ctr (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic       i_clr,
    input  logic [3:0] i_limit,
    output logic       o_at_limit
);
    logic [3:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_cnt <= 4'd0;
        else if (i_clr) r_cnt <= 4'd0;
        else if (i_inc && r_cnt != i_limit) r_cnt <= r_cnt + 4'd1;
    assign o_at_limit = r_cnt == i_limit;
endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: single-port VRAM arbiter between video character fetch and Avalon-MM,
// video wins by default and a starvation counter bounds the Avalon wait.
module vram_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int VRAM_WORDS   = vram_arb_pkg::VRAM_WORDS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [3:0]        AVL_BYTE_EN,
    input  logic [ADDR_W-1:0] AVL_ADDR,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    output logic              AVL_WAITREQUEST,
    input  logic              VID_REQ,
    input  logic [9:0]        VID_ADDR,
    output logic              VID_GNT,
    output logic              VID_VALID,
    output logic [31:0]       VID_DATA,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [3:0]        RAM_BYTEENA,
    output logic [31:0]       RAM_DATA,
    output logic              RAM_WREN,
    input  logic [31:0]       RAM_Q
);
    import vram_arb_pkg::*;

    arb_state_t r_state;
    logic       r_vid_valid;
    gnt_t       w_gnt;
    logic       w_req, w_idle, w_in_range, w_pend, w_oor, w_at_limit, w_avl_gnt, w_avl_wr, w_complete;

    assign w_req      = AVL_CS & (AVL_READ | AVL_WRITE);
    assign w_idle     = r_state == IDLE;
    assign w_in_range = 32'(AVL_ADDR) < VRAM_WORDS;
    assign w_pend     = w_req & w_idle & w_in_range;
    // Grants and out-of-range completion are suppressed while reset is held
    assign w_oor      = RESET_N & w_req & w_idle & ~w_in_range;
    assign w_gnt      = !RESET_N               ? GNT_NONE :
                        (w_pend && w_at_limit) ? GNT_AVL  :
                        VID_REQ                ? GNT_VID  :
                        w_pend                 ? GNT_AVL  : GNT_NONE;
    assign w_avl_gnt  = w_gnt == GNT_AVL;
    assign w_avl_wr   = w_avl_gnt & AVL_WRITE;
    assign w_complete = w_avl_wr | w_oor | (r_state == RD_RET);

    assign AVL_WAITREQUEST = w_req & ~w_complete;
    assign AVL_READDATA    = (r_state == RD_RET) ? RAM_Q : 32'd0;
    assign VID_GNT         = w_gnt == GNT_VID;
    assign VID_VALID       = r_vid_valid;
    assign VID_DATA        = RAM_Q;
    assign RAM_WREN        = w_avl_wr;
    assign RAM_ADDR        = VID_GNT ? ADDR_W'(VID_ADDR) : w_avl_gnt ? AVL_ADDR : '0;
    assign RAM_BYTEENA     = w_avl_wr ? AVL_BYTE_EN : 4'd0;
    assign RAM_DATA        = w_avl_wr ? AVL_WRITEDATA : 32'd0;

    vram_arb_starve_ctr u_starve (
        .i_clk      (CLK),
        .i_rst_n    (RESET_N),
        .i_inc      (w_pend & ~w_avl_gnt),
        .i_clr      (~w_pend | w_avl_gnt),
        .i_limit    (4'(STARVE_LIMIT)),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_vid_valid <= 1'b0;
        end else begin
            r_state     <= (w_idle && w_avl_gnt && !AVL_WRITE) ? RD_RET : IDLE;
            r_vid_valid <= VID_GNT;
        end
endmodule
